// File: rtl/alloc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alloc_arbiter
// Brief    : Round-robin arbiter sharing one allocator among N_REQ requesters.
//            Optional macro ALLOC_ARB_STICKY_ERR_EN adds o_err_sticky/o_err_src.
// Revision : 1.0
// ============================================================================
module alloc_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_SZ = 16,
    parameter int RAM_ASZ = 8,
    parameter int LATENCY = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [2*N_REQ-1:0]       i_req_op,
    input  logic [DATA_SZ*N_REQ-1:0] i_req_addr,
    input  logic [DATA_SZ*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [N_REQ-1:0]         o_rsp_valid,
    output logic [DATA_SZ-1:0]       o_rsp_data,
    output logic                     o_rsp_err,
    output logic                     o_busy,
    output logic                     o_alloc,
    output logic                     o_free,
    output logic                     o_wr,
    output logic                     o_rd,
    output logic [DATA_SZ-1:0]       o_data,
    output logic [DATA_SZ-1:0]       o_addr,
    output logic [RAM_ASZ-1:0]       o_waddr,
    output logic [RAM_ASZ-1:0]       o_raddr,
    output logic [DATA_SZ-1:0]       o_wdata,
    input  logic [DATA_SZ-1:0]       i_addr,
    input  logic [DATA_SZ-1:0]       i_rdata,
    input  logic                     i_err
`ifdef ALLOC_ARB_STICKY_ERR_EN
    ,
    output logic                     o_err_sticky,
    output logic [$clog2(N_REQ)-1:0] o_err_src
`endif
);

    localparam int c_PTR_W = $clog2(N_REQ);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [1:0] c_OP_ALLOC = 2'b00;
    localparam logic [1:0] c_OP_FREE  = 2'b01;
    localparam logic [1:0] c_OP_RD    = 2'b10;
    localparam logic [1:0] c_OP_WR    = 2'b11;

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] r_gnt;
    logic [c_PTR_W-1:0] w_gnt_idx;
    logic               w_found;
    int                 w_rr_idx;
    logic [1:0]         r_op;
    logic [1:0]         w_sel_op;
    logic [DATA_SZ-1:0] r_addr;
    logic [DATA_SZ-1:0] r_data;
    logic [2:0]         r_wait_cnt;
    logic               w_wait_done;
    logic               r_err_cap;
    logic               r_alloc, r_free, r_wr, r_rd;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [DATA_SZ-1:0] r_rsp_data;
    logic               r_rsp_err;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    // First valid requester at or above the pointer, wrapping to 0.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_rr_idx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_rr_idx = int'(r_ptr) + k;
            if (w_rr_idx >= N_REQ) begin
                w_rr_idx = w_rr_idx - N_REQ;
            end
            if (!w_found && i_req_valid[w_rr_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = c_PTR_W'(w_rr_idx);
            end
        end
    end

    assign w_sel_op    = i_req_op[2*w_gnt_idx +: 2];
    assign w_wait_done = (r_wait_cnt == 3'(LATENCY - 1));

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_found) w_state_nxt = c_ISSUE;
            c_ISSUE: w_state_nxt = c_WAIT;
            c_WAIT:  if (w_wait_done) w_state_nxt = c_RESP;
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Ready is combinational so a grant costs no cycle; gated so reset shows all-zero.
    always_comb begin
        o_req_ready = '0;
        if (w_rst_n && (r_state == c_IDLE) && w_found) begin
            o_req_ready = N_REQ'(1) << w_gnt_idx;
        end
        o_busy = (r_state != c_IDLE) || (o_req_ready != '0);
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_op        <= 2'b00;
            r_addr      <= '0;
            r_data      <= '0;
            r_wait_cnt  <= 3'd0;
            r_err_cap   <= 1'b0;
            r_alloc     <= 1'b0;
            r_free      <= 1'b0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_alloc     <= 1'b0;
            r_free      <= 1'b0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt_idx;
                        r_op    <= w_sel_op;
                        r_addr  <= i_req_addr[DATA_SZ*w_gnt_idx +: DATA_SZ];
                        r_data  <= i_req_data[DATA_SZ*w_gnt_idx +: DATA_SZ];
                        r_alloc <= (w_sel_op == c_OP_ALLOC);
                        r_free  <= (w_sel_op == c_OP_FREE);
                        r_rd    <= (w_sel_op == c_OP_RD);
                        r_wr    <= (w_sel_op == c_OP_WR);
                    end
                end
                c_ISSUE: begin
                    r_err_cap  <= 1'b0;
                    r_wait_cnt <= 3'd0;
                end
                c_WAIT: begin
                    r_err_cap  <= r_err_cap | i_err;
                    r_wait_cnt <= r_wait_cnt + 3'd1;
                    if (w_wait_done) begin
                        r_rsp_valid <= N_REQ'(1) << r_gnt;
                        r_rsp_err   <= r_err_cap | i_err;
                        case (r_op)
                            c_OP_ALLOC: r_rsp_data <= i_addr;
                            c_OP_RD:    r_rsp_data <= i_rdata;
                            default:    r_rsp_data <= '0;
                        endcase
                    end
                end
                c_RESP: begin
                    r_ptr <= (r_gnt == c_PTR_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ALLOC_ARB_STICKY_ERR_EN
    logic               r_err_sticky;
    logic [c_PTR_W-1:0] r_err_src;

    // Source is frozen at the first error so later faults do not mask it.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_err_sticky <= 1'b0;
            r_err_src    <= '0;
        end else if ((r_state == c_RESP) && r_rsp_err && !r_err_sticky) begin
            r_err_sticky <= 1'b1;
            r_err_src    <= r_gnt;
        end
    end
    assign o_err_sticky = r_err_sticky;
    assign o_err_src    = r_err_src;
`endif

    assign o_alloc     = r_alloc;
    assign o_free      = r_free;
    assign o_wr        = r_wr;
    assign o_rd        = r_rd;
    assign o_data      = r_data;
    assign o_addr      = r_addr;
    assign o_wdata     = r_data;
    assign o_waddr     = r_addr[RAM_ASZ-1:0];
    assign o_raddr     = r_addr[RAM_ASZ-1:0];
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alloc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alloc_arbiter
// Brief    : Directed self-checking bench for alloc_arbiter with a 1-cycle allocator model.
// Revision : 1.0
// ============================================================================
module tb_alloc_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int LAT = 1;

    localparam logic [1:0] OP_ALLOC = 2'b00;
    localparam logic [1:0] OP_FREE  = 2'b01;
    localparam logic [1:0] OP_RD    = 2'b10;
    localparam logic [1:0] OP_WR    = 2'b11;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_op;
    logic [DW*N-1:0] req_addr;
    logic [DW*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            s_alloc, s_free, s_wr, s_rd;
    logic [DW-1:0]   a_data, a_addr, a_wdata;
    logic [AW-1:0]   a_waddr, a_raddr;
    logic [DW-1:0]   m_addr, m_rdata;
    logic            m_err;
`ifdef ALLOC_ARB_STICKY_ERR_EN
    logic            err_sticky;
    logic [1:0]      err_src;
`endif

    logic [DW-1:0]   mem [0:(1<<AW)-1];
    logic [DW-1:0]   alloc_ret;
    logic            err_on_free;
    int              n_checks;
    int              n_pass;

    alloc_arbiter #(.N_REQ(N), .DATA_SZ(DW), .RAM_ASZ(AW), .LATENCY(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_op    (req_op),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy),
        .o_alloc     (s_alloc),
        .o_free      (s_free),
        .o_wr        (s_wr),
        .o_rd        (s_rd),
        .o_data      (a_data),
        .o_addr      (a_addr),
        .o_waddr     (a_waddr),
        .o_raddr     (a_raddr),
        .o_wdata     (a_wdata),
        .i_addr      (m_addr),
        .i_rdata     (m_rdata),
        .i_err       (m_err)
`ifdef ALLOC_ARB_STICKY_ERR_EN
        ,
        .o_err_sticky(err_sticky),
        .o_err_src   (err_src)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Allocator model: results valid one cycle after the strobe.
    always @(posedge clk) begin
        if (s_alloc) m_addr <= alloc_ret;
        if (s_rd) m_rdata <= mem[a_raddr];
        if (s_wr) mem[a_waddr] <= a_wdata;
        m_err <= s_free & err_on_free;
    end

    always @(negedge clk) begin
        if (s_alloc | s_free | s_wr | s_rd) begin
            n_checks++;
            assert ($onehot({s_alloc, s_free, s_wr, s_rd})) n_pass++;
            else $error("FAIL strobe_overlap: observed %b expected one-hot",
                        {s_alloc, s_free, s_wr, s_rd});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input int idx, input logic [1:0] op, input logic [DW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW-1:0] exp_data,
                          input logic exp_err);
        logic [3:0] exp_strb;
        exp_strb = (op == OP_ALLOC) ? 4'b1000 : (op == OP_FREE) ? 4'b0100 :
                   (op == OP_RD)    ? 4'b0010 : 4'b0001;
        req_valid              = '0;
        req_valid[idx]         = 1'b1;
        req_op[2*idx +: 2]     = op;
        req_addr[DW*idx +: DW] = addr;
        req_data[DW*idx +: DW] = data;
        #1;
        chk("accept_ready", 32'(req_ready), 32'(1) << idx);
        chk("accept_busy", 32'(busy), 32'd1);
        step();
        req_valid[idx] = 1'b0;
        chk("issue_strobe", 32'({s_alloc, s_free, s_rd, s_wr}), 32'(exp_strb));
        if (op == OP_ALLOC) chk("issue_data", 32'(a_data), 32'(data));
        if (op == OP_FREE)  chk("issue_addr", 32'(a_addr), 32'(addr));
        if (op == OP_RD)    chk("issue_raddr", 32'(a_raddr), 32'(addr[AW-1:0]));
        if (op == OP_WR) begin
            chk("issue_waddr", 32'(a_waddr), 32'(addr[AW-1:0]));
            chk("issue_wdata", 32'(a_wdata), 32'(data));
        end
        step();
        chk("wait_strobe", 32'({s_alloc, s_free, s_rd, s_wr}), 32'd0);
        repeat (LAT) step();
        chk("resp_valid", 32'(rsp_valid), 32'(1) << idx);
        chk("resp_data", 32'(rsp_data), 32'(exp_data));
        chk("resp_err", 32'(rsp_err), 32'(exp_err));
        step();
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_data_hold", 32'(rsp_data), 32'(exp_data));
        chk("post_err_hold", 32'(rsp_err), 32'(exp_err));
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [N-1:0] rsp_acc;
        int cyc;
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_op      = '0;
        req_addr    = '0;
        req_data    = '0;
        alloc_ret   = '0;
        err_on_free = 1'b0;
        m_addr      = '0;
        m_rdata     = '0;
        m_err       = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        step();
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_strobes", 32'({s_alloc, s_free, s_rd, s_wr}), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Reset in the middle of an RD wait: command dropped, no response.
        req_valid        = 4'b0010;
        req_op[3:2]      = OP_RD;
        req_addr[31:16]  = 16'd3;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("t1_rd", 32'(s_rd), 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("t1_rst_strobes", 32'({s_alloc, s_free, s_rd, s_wr}), 32'd0);
        chk("t1_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        step();
        step();
        rst_n   = 1'b1;
        rsp_acc = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            rsp_acc = rsp_acc | rsp_valid;
        end
        chk("t1_no_rsp", 32'(rsp_acc), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // All four requesting RD continuously: 0,1,2,3 then wrap to 0.
        req_valid = 4'b1111;
        req_op    = 8'hAA;
        req_addr  = '0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("t3_grant", 32'(req_ready), 32'(1) << g);
            cyc = 0;
            do begin
                step();
                cyc++;
            end while (req_ready == '0 && cyc < 12);
            chk("t3_spacing", 32'(cyc), 32'(LAT + 3));
        end
        chk("t3_wrap_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        #1;
        chk("t3_drop_ignored", 32'(req_ready), 32'd0);
        step();
        chk("t3_drop_busy", 32'(busy), 32'd0);

        // Single ALLOC, then the same sole requester back to back.
        alloc_ret = 16'h5001;
        do_cmd(0, OP_ALLOC, 16'h0000, 16'h0000, 16'h5001, 1'b0);
        alloc_ret = 16'h5002;
        do_cmd(0, OP_ALLOC, 16'h0000, 16'h1234, 16'h5002, 1'b0);

        // WR then RD of the same RAM word; RD address has bits above RAM_ASZ.
        do_cmd(2, OP_WR, 16'h0007, 16'h0005, 16'h0000, 1'b0);
        do_cmd(1, OP_RD, 16'h0107, 16'h0000, 16'h0005, 1'b0);

        // FREE with allocator error, then a clean command clears the per-response flag.
        err_on_free = 1'b1;
        do_cmd(3, OP_FREE, 16'h5001, 16'h0000, 16'h0000, 1'b1);
        err_on_free = 1'b0;
`ifdef ALLOC_ARB_STICKY_ERR_EN
        chk("t5_sticky", 32'(err_sticky), 32'd1);
        chk("t5_src", 32'(err_src), 32'd3);
`endif
        alloc_ret = 16'h5003;
        do_cmd(0, OP_ALLOC, 16'h0000, 16'h0000, 16'h5003, 1'b0);
`ifdef ALLOC_ARB_STICKY_ERR_EN
        chk("t5_sticky_hold", 32'(err_sticky), 32'd1);
        chk("t5_src_hold", 32'(err_src), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t5_sticky_clr", 32'(err_sticky), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
